regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy
//  scoreboard. Provides NUM_RD combinational read ports and NUM_WR write ports
//  with write-to-read bypass, and tracks pending producers for the decode/issue
//  stage. Sits between decode (reads, issue marks) and writeback (writes,
//  busy clears). It is the next-generation register file of the CPU.
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of registers (power of 2, >=2); AW = $clog2(NREGS)
//  NUM_RD  2   number of read ports (>=1)
//  NUM_WR  2   number of write ports (>=1); higher index = higher priority
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             synchronous, active-high
//  rd_addr      in   NUM_RD*AW     read addresses, one AW slice per read port
//  rd_data      out  NUM_RD*XLEN   read data (combinational, bypassed)
//  rd_busy      out  NUM_RD        addressed register has a pending producer
//  wr_en        in   NUM_WR        write enables
//  wr_addr      in   NUM_WR*AW     write addresses
//  wr_data      in   NUM_WR*XLEN   write data
//  issue_valid  in   1             mark issue_rd busy (new producer issued)
//  issue_rd     in   AW            destination register being issued
//  busy_vec     out  NREGS         registered busy bits, bit 0 always 0
// BEHAVIOUR
//  - Single clock; reset synchronous active-high. On a reset edge all
//    registers are 0 and all busy bits are 0; reset overrides any same-cycle
//    write or issue. While reset is high, rd_data returns bypassed write data
//    or the stored value (0 after the first reset edge).
//  - Register 0 is hardwired to zero: writes to address 0 are dropped, reads
//    of 0 return 0 with rd_busy=0, issue to 0 sets no busy bit.
//  - Writes: on the rising clock edge, regs[wr_addr[w]] <= wr_data[w] for each
//    enabled port. Two or more ports writing the same address in one cycle:
//    the highest-index port wins.
//  - Reads: zero latency. Bypass: if any enabled write port targets rd_addr[r]
//    (r!=0) in the same cycle, rd_data[r] = that port's wr_data, using the same
//    priority as the write; otherwise the stored value.
//  - Scoreboard, next state per register i (i!=0):
//    set   = issue_valid && issue_rd==i
//    clear = any wr_en[w] && wr_addr[w]==i
//    busy_next = set ? 1 : (clear ? 0 : busy)
//    Set takes priority over clear, because a newer producer supersedes the
//    write being retired.
//  - rd_busy[r] = busy[rd_addr[r]] && !clear(rd_addr[r]). This is
//    combinational, so a same-cycle writeback un-stalls the reader. A
//    same-cycle issue does not raise rd_busy.
//  - busy_vec exposes the registered busy bits with no bypass.
//  - Latency: write-to-storage takes 1 cycle; write-to-read is 0 cycles via
//    bypass; issue-to-busy_vec takes 1 cycle.
//  - Register state has no other reset path; there is no X on any output
//    after the first reset edge.
// STRUCTURE
//  - regfile_pkg holds: localparam XLEN_DEF=32, NREGS_DEF=32, typedef
//    reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]) for the default
//    configuration.
//  - One sub-module, regfile_scoreboard: holds the busy bits, the issue and
//    clear inputs, busy_vec, and per-port rd_busy. The storage array, write
//    priority and bypass muxes stay in the top.
// TESTING
//  - Reset: preload r5=0x1234, assert reset 1 cycle -> read r5 = 0,
//    busy_vec = 0.
//  - x0: write r0=0xDEADBEEF, issue rd=0 -> rd_data(r0)=0, busy_vec[0]=0,
//    rd_busy=0.
//  - Write conflict and bypass: wr0 (r7,0x11) with wr1 (r7,0x22) in the same
//    cycle -> same-cycle read r7=0x22; next cycle read r7=0x22.
//  - Scoreboard: issue r3 -> next cycle busy_vec[3]=1 and rd_busy(r3)=1;
//    write r3=0x55 -> same cycle rd_busy=0, rd_data=0x55; next cycle
//    busy_vec[3]=0.
//  - Set beats clear: with r4 busy, issue r4 and write r4=9 in the same
//    cycle -> busy_vec[4] stays 1; r4 reads 9.
//  - Reset mid-operation: r3 busy and a write to r3 pending on the reset
//    edge -> busy cleared and r3=0; parametrised run with NREGS=16,
//    NUM_RD=3 repeats the tests above.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits tracking pending producers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NREGS-1:0]     busy_vec,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr;

  // Registers being retired by any write port this cycle
  always_comb begin
    clr = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) clr[wr_addr[w*AW +: AW]] = 1'b1;
    end
  end

  // A newly issued producer supersedes the write being retired; x0 never busy
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (issue_valid && issue_rd == AW'(i)) busy_d[i] = 1'b1;
      else if (clr[i])                       busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit storage
  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // Same-cycle writeback un-stalls the reader; same-cycle issue does not stall it
  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_busy[r] = busy_q[rd_addr[r*AW +: AW]] & ~clr[rd_addr[r*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port register file with bypass and busy scoreboard
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Storage writes; later ports in the loop override earlier ones, x0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Zero-latency reads with write bypass using the same port priority as storage
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = rd_addr[r*AW +: AW];
      rv = regs[ra];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == ra) rv = wr_data[w*XLEN +: XLEN];
      end
      if (ra == '0) rv = '0;
      rd_data[r*XLEN +: XLEN] = rv;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .busy_vec    (busy_vec),
    .rd_busy     (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - self-checking bench for two register file configurations
module tb_regfile_mp_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  int          wa [2];
  logic [31:0] wd [2];
  int          rd_a [3];
  logic        issue_valid;
  int          issue_rd_i;

  logic [9:0]  rd_addr_a;
  logic [11:0] rd_addr_b;
  logic [9:0]  wr_addr_a;
  logic [7:0]  wr_addr_b;
  logic [63:0] wr_data;
  logic [4:0]  issue_rd_a;
  logic [3:0]  issue_rd_b;

  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [31:0] busy_vec_a;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_busy_b;
  logic [15:0] busy_vec_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_m [32];
  logic [31:0] busy_m;
  bit          model_valid = 1'b0;

  always #5 clock = ~clock;

  always_comb begin
    rd_addr_a  = {rd_a[1][4:0], rd_a[0][4:0]};
    rd_addr_b  = {rd_a[2][3:0], rd_a[1][3:0], rd_a[0][3:0]};
    wr_addr_a  = {wa[1][4:0], wa[0][4:0]};
    wr_addr_b  = {wa[1][3:0], wa[0][3:0]};
    wr_data    = {wd[1], wd[0]};
    issue_rd_a = issue_rd_i[4:0];
    issue_rd_b = issue_rd_i[3:0];
  end

  regfile_mp_scoreboard dut_a (
    .clock       (clock),
    .reset       (reset),
    .rd_addr     (rd_addr_a),
    .rd_data     (rd_data_a),
    .rd_busy     (rd_busy_a),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr_a),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd_a),
    .busy_vec    (busy_vec_a)
  );

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(16), .NUM_RD(3), .NUM_WR(2)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .rd_addr     (rd_addr_b),
    .rd_data     (rd_data_b),
    .rd_busy     (rd_busy_b),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr_b),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd_b),
    .busy_vec    (busy_vec_b)
  );

  // Expected read value: x0 is zero, latest enabled write port wins, else stored value
  function automatic logic [31:0] exp_rd(int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = mem_m[a];
    for (int w = 0; w < 2; w++) if (wr_en[w] && wa[w] == a) v = wd[w];
    return v;
  endfunction

  function automatic logic [31:0] exp_rb(int a);
    if (a == 0) return 32'h0;
    for (int w = 0; w < 2; w++) if (wr_en[w] && wa[w] == a) return 32'h0;
    return {31'h0, busy_m[a]};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model advanced on every rising edge
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
      busy_m      = 32'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      logic [31:0] retired;
      retired = 32'h0;
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && wa[w] != 0) begin
          mem_m[wa[w]] = wd[w];
          retired[wa[w]] = 1'b1;
        end
      end
      for (int i = 1; i < 32; i++) begin
        if (issue_valid && issue_rd_i == i) busy_m[i] = 1'b1;
        else if (retired[i])                busy_m[i] = 1'b0;
      end
    end
  end

  // Continuous comparison of both configurations against the model
  always @(negedge clock) begin
    if (model_valid) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("a_rd_data%0d", p), rd_data_a[p*32 +: 32], exp_rd(rd_a[p]));
        check($sformatf("a_rd_busy%0d", p), {31'h0, rd_busy_a[p]}, exp_rb(rd_a[p]));
      end
      for (int p = 0; p < 3; p++) begin
        check($sformatf("b_rd_data%0d", p), rd_data_b[p*32 +: 32], exp_rd(rd_a[p]));
        check($sformatf("b_rd_busy%0d", p), {31'h0, rd_busy_b[p]}, exp_rb(rd_a[p]));
      end
      check("a_busy_vec", busy_vec_a, busy_m);
      check("b_busy_vec", {16'h0, busy_vec_b}, {16'h0, busy_m[15:0]});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en       = 2'b00;
    wa[0]       = 0;
    wa[1]       = 0;
    wd[0]       = 32'h0;
    wd[1]       = 32'h0;
    issue_valid = 1'b0;
    issue_rd_i  = 0;
  endtask

  task automatic lit_rd(string nm, int p, logic [31:0] exp);
    check({"a_", nm}, rd_data_a[p*32 +: 32], exp);
    check({"b_", nm}, rd_data_b[p*32 +: 32], exp);
  endtask

  task automatic lit_rb(string nm, int p, logic exp);
    check({"a_", nm}, {31'h0, rd_busy_a[p]}, {31'h0, exp});
    check({"b_", nm}, {31'h0, rd_busy_b[p]}, {31'h0, exp});
  endtask

  task automatic lit_bv(string nm, logic [31:0] exp);
    check({"a_", nm}, busy_vec_a, exp);
    check({"b_", nm}, {16'h0, busy_vec_b}, {16'h0, exp[15:0]});
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_a[0] = 0; rd_a[1] = 0; rd_a[2] = 0;
    tick();
    tick();
    reset = 1'b0;

    // Preload r5 and mark r6 busy, then reset
    wr_en = 2'b01; wa[0] = 5; wd[0] = 32'h1234;
    issue_valid = 1'b1; issue_rd_i = 6; rd_a[0] = 5;
    #3 lit_rd("preload_bypass", 0, 32'h1234);
    tick();
    idle();
    #3 lit_rd("preload_stored", 0, 32'h1234);
    lit_bv("preload_busy", 32'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3 lit_rd("reset_r5", 0, 32'h0);
    lit_bv("reset_busy", 32'h0);

    // x0 is hardwired
    wr_en = 2'b01; wa[0] = 0; wd[0] = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd_i = 0; rd_a[0] = 0;
    #3 lit_rd("x0_same", 0, 32'h0);
    lit_rb("x0_busy", 0, 1'b0);
    tick();
    idle();
    #3 lit_rd("x0_next", 0, 32'h0);
    lit_bv("x0_bv", 32'h0);

    // Write conflict, highest port wins in both bypass and storage
    wr_en = 2'b11; wa[0] = 7; wd[0] = 32'h11; wa[1] = 7; wd[1] = 32'h22;
    rd_a[0] = 7; rd_a[1] = 7;
    #3 lit_rd("conflict_byp0", 0, 32'h22);
    lit_rd("conflict_byp1", 1, 32'h22);
    tick();
    idle();
    #3 lit_rd("conflict_stored", 0, 32'h22);

    // Issue then writeback of r3
    issue_valid = 1'b1; issue_rd_i = 3; rd_a[0] = 3;
    #3 lit_rb("issue_same_cycle", 0, 1'b0);
    tick();
    idle();
    #3 lit_bv("issue_bv", 32'h8);
    lit_rb("issue_rd_busy", 0, 1'b1);
    wr_en = 2'b01; wa[0] = 3; wd[0] = 32'h55;
    #3 lit_rb("wb_unstall", 0, 1'b0);
    lit_rd("wb_bypass", 0, 32'h55);
    tick();
    idle();
    #3 lit_bv("wb_cleared", 32'h0);
    lit_rd("wb_stored", 0, 32'h55);

    // Set beats clear on r4
    issue_valid = 1'b1; issue_rd_i = 4;
    tick();
    issue_valid = 1'b1; issue_rd_i = 4;
    wr_en = 2'b10; wa[1] = 4; wd[1] = 32'h9; rd_a[1] = 4;
    #3 lit_rd("setclr_byp", 1, 32'h9);
    lit_rb("setclr_rb", 1, 1'b0);
    tick();
    idle();
    #3 lit_bv("setclr_bv", 32'h10);
    lit_rd("setclr_r4", 1, 32'h9);
    lit_rb("setclr_still_busy", 1, 1'b1);

    // Reset overrides a pending write and busy state
    issue_valid = 1'b1; issue_rd_i = 3; rd_a[0] = 3;
    tick();
    idle();
    #3 lit_bv("midop_bv", 32'h18);
    reset = 1'b1;
    wr_en = 2'b01; wa[0] = 3; wd[0] = 32'h77;
    tick();
    reset = 1'b0;
    idle();
    #3 lit_rd("midop_r3", 0, 32'h0);
    lit_bv("midop_bv_clear", 32'h0);

    // Mixed traffic checked by the model only
    for (int n = 0; n < 120; n++) begin
      reset       = ($urandom_range(0, 29) == 0);
      wr_en       = 2'($urandom_range(0, 3));
      wa[0]       = $urandom_range(0, 7);
      wa[1]       = $urandom_range(0, 7);
      wd[0]       = $urandom;
      wd[1]       = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd_i  = $urandom_range(0, 7);
      rd_a[0]     = $urandom_range(0, 7);
      rd_a[1]     = $urandom_range(0, 7);
      rd_a[2]     = $urandom_range(0, 15);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
